roi_pixel_stats: RTL and testbench

- Downstream consumer of the radar region-readout stage.
- Takes the framed pixel stream, which is pixel_out framed by data_start/data_end, together with the region descriptor (row/col corners, channel).
- Computes per-region statistics: pixel count, sum, peak value, peak coordinates and a length-check flag.
- Presents them as one result word with a single-cycle valid pulse for the detection/reporting logic.

---
 rtl/roi_pixel_stats.sv | 233 +++++++++++++++++++++++
 tb/tb_roi_pixel_stats.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/roi_pixel_stats.sv
`default_nettype none
// ============================================================================
// Module   : roi_pixel_stats
// Brief    : Per-region pixel statistics (count, sum, peak, peak position,
//            length check) over a data_start/data_end framed pixel stream.
// Revision : 1.0
// ============================================================================
module roi_pixel_stats #(
    parameter int PIX_W = 16,
    parameter int IDX_W = 10,
    parameter int CH_W  = 4,
    parameter int CNT_W = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDX_W-1:0]       row_idx1,
    input  logic [IDX_W-1:0]       col_idx1,
    input  logic [IDX_W-1:0]       row_idx2,
    input  logic [IDX_W-1:0]       col_idx2,
    input  logic [CH_W-1:0]        channel_num,
    input  logic                   data_start,
    input  logic                   data_end,
    input  logic [PIX_W-1:0]       pixel_out,
    output logic                   stat_valid,
    output logic [CH_W-1:0]        stat_channel,
    output logic [CNT_W-1:0]       pix_count,
    output logic [PIX_W+CNT_W-1:0] pix_sum,
    output logic [PIX_W-1:0]       pix_max,
    output logic [IDX_W-1:0]       max_row,
    output logic [IDX_W-1:0]       max_col,
    output logic                   len_err,
    output logic                   busy
);

    localparam int SUM_W = PIX_W + CNT_W;
    localparam int CMP_W = (CNT_W > 2*IDX_W+2) ? CNT_W : 2*IDX_W+2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [PIX_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] mrow_q, mrow_d, mcol_q, mcol_d;
    logic [IDX_W-1:0] prow_q, prow_d, pcol_q, pcol_d;

    logic [CH_W-1:0]  stat_channel_q, stat_channel_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;
    logic [SUM_W-1:0] pix_sum_q, pix_sum_d;
    logic [PIX_W-1:0] pix_max_q, pix_max_d;
    logic [IDX_W-1:0] max_row_q, max_row_d, max_col_q, max_col_d;
    logic             len_err_q, len_err_d;

    logic [IDX_W-1:0] w_nrow, w_ncol;
    logic [IDX_W:0]   w_row_span, w_col_span;
    logic [CMP_W-1:0] w_expected;
    logic             w_len_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; data_start restarts a region from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (data_start) state_d = data_end ? S_DONE : S_ACCUM;
                else            state_d = S_IDLE;
            end
            S_ACCUM: begin
                if (data_start)    state_d = data_end ? S_DONE : S_ACCUM;
                else if (data_end) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stat_valid = (state_q == S_DONE);
        busy       = (state_q == S_ACCUM);
    end

    // Raster pointer advance, clamped once the end corner is reached
    always_comb begin
        w_nrow = prow_q;
        w_ncol = pcol_q;
        if (!(prow_q == r2_q && pcol_q == c2_q)) begin
            if (pcol_q == c2_q) begin
                w_ncol = c1_q;
                w_nrow = prow_q + IDX_W'(1);
            end else begin
                w_ncol = pcol_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        r1_d   = r1_q;
        c1_d   = c1_q;
        r2_d   = r2_q;
        c2_d   = c2_q;
        ch_d   = ch_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        max_d  = max_q;
        mrow_d = mrow_q;
        mcol_d = mcol_q;
        prow_d = prow_q;
        pcol_d = pcol_q;

        if (data_start) begin
            r1_d   = row_idx1;
            c1_d   = col_idx1;
            r2_d   = row_idx2;
            c2_d   = col_idx2;
            ch_d   = channel_num;
            cnt_d  = CNT_W'(1);
            sum_d  = SUM_W'(pixel_out);
            max_d  = pixel_out;
            mrow_d = row_idx1;
            mcol_d = col_idx1;
            prow_d = row_idx1;
            pcol_d = col_idx1;
        end else if (state_q == S_ACCUM) begin
            prow_d = w_nrow;
            pcol_d = w_ncol;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
                sum_d = sum_q + SUM_W'(pixel_out);
            end
            if (pixel_out > max_q) begin
                max_d  = pixel_out;
                mrow_d = w_nrow;
                mcol_d = w_ncol;
            end
        end
    end

    // Length check against the indices in effect for the finishing region
    always_comb begin
        w_row_span = {1'b0, r2_d} - {1'b0, r1_d} + (IDX_W+1)'(1);
        w_col_span = {1'b0, c2_d} - {1'b0, c1_d} + (IDX_W+1)'(1);
        w_expected = CMP_W'(w_row_span) * CMP_W'(w_col_span);
        w_len_err  = (r2_d < r1_d) || (c2_d < c1_d) || (cnt_d == CNT_MAX) ||
                     (CMP_W'(cnt_d) != w_expected);
    end

    // Result word is captured on the edge that enters DONE and then held
    always_comb begin
        stat_channel_d = stat_channel_q;
        pix_count_d    = pix_count_q;
        pix_sum_d      = pix_sum_q;
        pix_max_d      = pix_max_q;
        max_row_d      = max_row_q;
        max_col_d      = max_col_q;
        len_err_d      = len_err_q;
        if (state_d == S_DONE) begin
            stat_channel_d = ch_d;
            pix_count_d    = cnt_d;
            pix_sum_d      = sum_d;
            pix_max_d      = max_d;
            max_row_d      = mrow_d;
            max_col_d      = mcol_d;
            len_err_d      = w_len_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q           <= '0;
            c1_q           <= '0;
            r2_q           <= '0;
            c2_q           <= '0;
            ch_q           <= '0;
            cnt_q          <= '0;
            sum_q          <= '0;
            max_q          <= '0;
            mrow_q         <= '0;
            mcol_q         <= '0;
            prow_q         <= '0;
            pcol_q         <= '0;
            stat_channel_q <= '0;
            pix_count_q    <= '0;
            pix_sum_q      <= '0;
            pix_max_q      <= '0;
            max_row_q      <= '0;
            max_col_q      <= '0;
            len_err_q      <= 1'b0;
        end else begin
            r1_q           <= r1_d;
            c1_q           <= c1_d;
            r2_q           <= r2_d;
            c2_q           <= c2_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            sum_q          <= sum_d;
            max_q          <= max_d;
            mrow_q         <= mrow_d;
            mcol_q         <= mcol_d;
            prow_q         <= prow_d;
            pcol_q         <= pcol_d;
            stat_channel_q <= stat_channel_d;
            pix_count_q    <= pix_count_d;
            pix_sum_q      <= pix_sum_d;
            pix_max_q      <= pix_max_d;
            max_row_q      <= max_row_d;
            max_col_q      <= max_col_d;
            len_err_q      <= len_err_d;
        end
    end

    assign stat_channel = stat_channel_q;
    assign pix_count    = pix_count_q;
    assign pix_sum      = pix_sum_q;
    assign pix_max      = pix_max_q;
    assign max_row      = max_row_q;
    assign max_col      = max_col_q;
    assign len_err      = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_roi_pixel_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_roi_pixel_stats
// Brief    : Table-driven scoreboard bench for roi_pixel_stats.
// Revision : 1.0
// ============================================================================
module tb_roi_pixel_stats;

    typedef struct packed {
        logic [3:0]  ch;
        logic [19:0] cnt;
        logic [35:0] sum;
        logic [15:0] mx;
        logic [9:0]  mr;
        logic [9:0]  mc;
        logic        le;
    } res_t;

    typedef struct packed {
        res_t        r;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [9:0] r1;
        logic [9:0] c1;
        logic [9:0] r2;
        logic [9:0] c2;
        logic [3:0] ch;
        logic [3:0] n;
        res_t       e;
    } vec_t;

    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  row_idx1 = '0, col_idx1 = '0, row_idx2 = '0, col_idx2 = '0;
    logic [3:0]  channel_num = '0;
    logic        data_start = 1'b0, data_end = 1'b0;
    logic [15:0] pixel_out = '0;
    logic        stat_valid;
    logic [3:0]  stat_channel;
    logic [19:0] pix_count;
    logic [35:0] pix_sum;
    logic [15:0] pix_max;
    logic [9:0]  max_row, max_col;
    logic        len_err, busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    res_t mon_got;
    vec_t tbl [NV];
    int   pix [NV][8];

    roi_pixel_stats dut (
        .clk(clk), .rst_n(rst_n),
        .row_idx1(row_idx1), .col_idx1(col_idx1),
        .row_idx2(row_idx2), .col_idx2(col_idx2),
        .channel_num(channel_num),
        .data_start(data_start), .data_end(data_end), .pixel_out(pixel_out),
        .stat_valid(stat_valid), .stat_channel(stat_channel),
        .pix_count(pix_count), .pix_sum(pix_sum), .pix_max(pix_max),
        .max_row(max_row), .max_col(max_col), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic vec_t mk(int r1, int c1, int r2, int c2, int ch, int n,
                                int cnt, int sum, int mx, int mr, int mc, int le);
        vec_t v;
        v.r1 = 10'(r1); v.c1 = 10'(c1); v.r2 = 10'(r2); v.c2 = 10'(c2);
        v.ch = 4'(ch);  v.n = 4'(n);
        v.e.ch = 4'(ch); v.e.cnt = 20'(cnt); v.e.sum = 36'(sum);
        v.e.mx = 16'(mx); v.e.mr = 10'(mr); v.e.mc = 10'(mc); v.e.le = le[0];
        return v;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && stat_valid) begin
            checks++;
            mon_got = '{stat_channel, pix_count, pix_sum, pix_max, max_row, max_col, len_err};
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got ch=%0d cnt=%0d sum=%0d, none expected",
                         stat_channel, pix_count, pix_sum);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e.r || 32'(cyc) != mon_e.cyc) begin
                    failures++;
                    $display("FAIL result: got ch=%0d cnt=%0d sum=%0d max=%0d @(%0d,%0d) le=%0d cyc=%0d expected ch=%0d cnt=%0d sum=%0d max=%0d @(%0d,%0d) le=%0d cyc=%0d",
                             mon_got.ch, mon_got.cnt, mon_got.sum, mon_got.mx, mon_got.mr,
                             mon_got.mc, mon_got.le, cyc, mon_e.r.ch, mon_e.r.cnt,
                             mon_e.r.sum, mon_e.r.mx, mon_e.r.mr, mon_e.r.mc, mon_e.r.le,
                             mon_e.cyc);
                end
            end
        end
    end

    task automatic send(input vec_t v, input int p[8], input int gap);
        exp_t e;
        for (int i = 0; i < int'(v.n); i++) begin
            if (i == 0) begin
                row_idx1 = v.r1; col_idx1 = v.c1; row_idx2 = v.r2; col_idx2 = v.c2;
                channel_num = v.ch;
            end else begin
                row_idx1 = 10'($urandom); col_idx1 = 10'($urandom);
                row_idx2 = 10'($urandom); col_idx2 = 10'($urandom);
                channel_num = 4'($urandom);
            end
            data_start = (i == 0);
            data_end   = (i == int'(v.n) - 1);
            pixel_out  = 16'(p[i]);
            if (data_end) begin
                e.r = v.e;
                e.cyc = 32'(cyc + 1);
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (i == 0 && v.n > 1) check("busy_accum", 64'(busy), 64'd1);
        end
        data_start = 1'b0; data_end = 1'b0; pixel_out = 16'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        int rp [8];
        int wait_cnt;

        tbl[0] = mk(2, 5, 3, 7, 3, 6,    6, 250,    90, 3, 6, 0);
        pix[0] = '{10, 20, 30, 40, 90, 60, 0, 0};
        tbl[1] = mk(4, 4, 4, 4, 5, 1,    1, 65535, 65535, 4, 4, 0);
        pix[1] = '{65535, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = mk(0, 0, 0, 3, 1, 4,    4, 26,     9, 0, 1, 0);
        pix[2] = '{7, 9, 9, 1, 0, 0, 0, 0};
        tbl[3] = mk(0, 0, 1, 1, 2, 3,    3, 18,     7, 1, 0, 1);
        pix[3] = '{5, 6, 7, 0, 0, 0, 0, 0};
        tbl[4] = mk(0, 0, 1, 1, 2, 5,    5, 19,     9, 1, 1, 1);
        pix[4] = '{1, 2, 3, 4, 9, 0, 0, 0};
        tbl[5] = mk(3, 3, 2, 4, 7, 2,    2, 12,     8, 3, 4, 1);
        pix[5] = '{4, 8, 0, 0, 0, 0, 0, 0};
        tbl[6] = mk(10, 20, 11, 21, 15, 4, 4, 900, 300, 10, 21, 0);
        pix[6] = '{100, 300, 200, 300, 0, 0, 0, 0};
        tbl[7] = mk(1, 1, 1, 2, 0, 2,    2, 100,   50, 1, 1, 0);
        pix[7] = '{50, 50, 0, 0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(stat_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_outputs",
              {pix_count, pix_max, 28'(stat_channel) ^ 28'(max_row) ^ 28'(max_col)} | 64'(pix_sum) | 64'(len_err),
              64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) send(tbl[k], pix[k], 2);

        check("result_hold_cnt", 64'(pix_count), 64'd2);
        check("result_hold_valid", 64'(stat_valid), 64'd0);

        // Back-to-back: next region starts in the DONE cycle
        send(tbl[0], pix[0], 0);
        send(tbl[2], pix[2], 2);

        // Restart mid-region: the partial region must not be reported
        row_idx1 = 10'd0; col_idx1 = 10'd0; row_idx2 = 10'd1; col_idx2 = 10'd2;
        channel_num = 4'd4; data_start = 1'b1; data_end = 1'b0; pixel_out = 16'd1;
        @(posedge clk); #1;
        data_start = 1'b0; pixel_out = 16'd2;
        @(posedge clk); #1;
        rp = '{5, 9, 3, 9, 0, 0, 0, 0};
        send(mk(1, 1, 2, 2, 6, 4,   4, 26, 9, 1, 2, 0), rp, 2);

        // Asynchronous reset mid-region
        send(tbl[6], pix[6], 2);
        row_idx1 = 10'd2; col_idx1 = 10'd5; row_idx2 = 10'd3; col_idx2 = 10'd7;
        channel_num = 4'd3; data_start = 1'b1; pixel_out = 16'd10;
        @(posedge clk); #1;
        data_start = 1'b0; pixel_out = 16'd20;
        @(posedge clk); #1;
        pixel_out = 16'd30;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_count", 64'(pix_count), 64'd0);
        check("midreset_sum", 64'(pix_sum), 64'd0);
        check("midreset_max", 64'({pix_max, max_row, max_col}), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        data_end = 1'b1;
        @(posedge clk); #1;
        data_end = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_valid", 64'(stat_valid), 64'd0);
        send(tbl[1], pix[1], 2);
        send(tbl[0], pix[0], 3);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
